spi_master_seq: RTL

//  Sequences one SPI master frame (mode 0: CPOL=0, CPHA=0) per start request.

---
 rtl/spi_master_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_seq.sv
// spi_master_seq: one SPI mode-0 master frame per accepted start request.
// Sequence: IDLE -> SETUP (CS lead) -> XFER (DATA_W bits) -> HOLD (CS lag) -> DONE -> IDLE.
// Every output comes straight from a flop. Reset is synchronous and active low.
// Optional build macro SPI_LSB_FIRST_EN adds i_lsb_first, which selects LSB-first
// bit order per frame. Without the macro, frames are always MSB first.
module spi_master_seq #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4,
   parameter int CS_LEAD = 2,
   parameter int CS_LAG  = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_tx_data,
`ifdef SPI_LSB_FIRST_EN
   input  logic              i_lsb_first,
`endif
   input  logic              i_miso,
   output logic              o_sclk,
   output logic              o_mosi,
   output logic              o_cs_n,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_rx_data
);

   // NOTE: $clog2(1) is 0, so each counter gets at least one bit to stay a legal vector.
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W   = $clog2(DATA_W);
   localparam int TIM_MAX = (CS_LEAD > CS_LAG) ? CS_LEAD : CS_LAG;
   localparam int TIM_W   = (TIM_MAX > 1) ? $clog2(TIM_MAX) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
   localparam logic [TIM_W-1:0] LEAD_LAST = TIM_W'(CS_LEAD - 1);
   localparam logic [TIM_W-1:0] LAG_LAST  = TIM_W'(CS_LAG - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_XFER  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        r_state;
   logic [DIV_W-1:0]  r_div_cnt;
   logic [BIT_W-1:0]  r_bit_cnt;
   logic [TIM_W-1:0]  r_tim_cnt;
   logic [DATA_W-1:0] r_tx_shift;
   logic [DATA_W-1:0] r_rx_shift;
   logic [DATA_W-1:0] r_rx_data;
   logic              r_sclk;
   logic              r_mosi;
   logic              r_cs_n;
   logic              r_busy;
   logic              r_done;
`ifdef SPI_LSB_FIRST_EN
   logic              r_lsb_first;
`endif

   logic              w_accept;
   logic              w_div_end;
   logic              w_rise;
   logic              w_fall;
   logic              w_last_bit;
   logic              w_lag_end;
   logic              w_first_bit;
   logic              w_mosi_next;
   logic [DATA_W-1:0] w_tx_rot;
   logic [DATA_W-1:0] w_rx_next;

   // The divider wraps once per SCLK half-period. Whether that wrap is a rise or
   // a fall depends on the SCLK level the flop is currently driving.
   assign w_accept   = (r_state == S_IDLE) && i_start;
   assign w_div_end  = (r_state == S_XFER) && (r_div_cnt == DIV_LAST);
   assign w_rise     = w_div_end && !r_sclk;
   assign w_fall     = w_div_end && r_sclk;
   assign w_last_bit = (r_bit_cnt == BIT_LAST);
   assign w_lag_end  = (r_state == S_HOLD) && (r_tim_cnt == LAG_LAST);

   // The TX register rotates rather than shifts. Every bit stays live, and the
   // next MOSI bit is always the neighbour of the bit currently being sent.
`ifdef SPI_LSB_FIRST_EN
   assign w_first_bit = i_lsb_first ? i_tx_data[0] : i_tx_data[DATA_W-1];
   assign w_mosi_next = r_lsb_first ? r_tx_shift[1] : r_tx_shift[DATA_W-2];
   assign w_tx_rot    = r_lsb_first ? {r_tx_shift[0], r_tx_shift[DATA_W-1:1]}
                                    : {r_tx_shift[DATA_W-2:0], r_tx_shift[DATA_W-1]};
   assign w_rx_next   = r_lsb_first ? {i_miso, r_rx_shift[DATA_W-1:1]}
                                    : {r_rx_shift[DATA_W-2:0], i_miso};
`else
   assign w_first_bit = i_tx_data[DATA_W-1];
   assign w_mosi_next = r_tx_shift[DATA_W-2];
   assign w_tx_rot    = {r_tx_shift[DATA_W-2:0], r_tx_shift[DATA_W-1]};
   assign w_rx_next   = {r_rx_shift[DATA_W-2:0], i_miso};
`endif

   // Frame sequencer: state, divider/bit/timing counters, SCLK, CS_n, busy and done.
   always_ff @(posedge i_clk) begin
      // NOTE: reset is tested inside the clocked block, so it takes effect only on
      // a clock edge. A mid-frame reset therefore leaves CS_n high one cycle later.
      if (!i_rst) begin
         r_state   <= S_IDLE;
         r_div_cnt <= '0;
         r_bit_cnt <= '0;
         r_tim_cnt <= '0;
         r_sclk    <= 1'b0;
         r_cs_n    <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop in this block updating from
         // the pre-edge values, whatever order the statements are written in.
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state <= S_SETUP;
                  r_cs_n  <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            S_SETUP: begin
               if (r_tim_cnt == LEAD_LAST) begin
                  r_tim_cnt <= '0;
                  r_state   <= S_XFER;
               end else begin
                  r_tim_cnt <= r_tim_cnt + 1'b1;
               end
            end
            S_XFER: begin
               if (w_div_end) begin
                  r_div_cnt <= '0;
                  r_sclk    <= ~r_sclk;
                  if (r_sclk) begin
                     if (w_last_bit) begin
                        r_bit_cnt <= '0;
                        r_state   <= S_HOLD;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                     end
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
            S_HOLD: begin
               if (r_tim_cnt == LAG_LAST) begin
                  r_tim_cnt <= '0;
                  r_state   <= S_DONE;
                  r_cs_n    <= 1'b1;
                  r_done    <= 1'b1;
               end else begin
                  r_tim_cnt <= r_tim_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_sclk  <= 1'b0;
               r_cs_n  <= 1'b1;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Data path: latch the frame on acceptance, move MOSI on SCLK falls, sample MISO
   // on SCLK rises, publish the received word on entry to DONE.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_tx_shift  <= '0;
         r_rx_shift  <= '0;
         r_rx_data   <= '0;
         r_mosi      <= 1'b0;
`ifdef SPI_LSB_FIRST_EN
         r_lsb_first <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_tx_shift  <= i_tx_data;
            r_mosi      <= w_first_bit;
`ifdef SPI_LSB_FIRST_EN
            r_lsb_first <= i_lsb_first;
`endif
         end else if (w_fall && !w_last_bit) begin
            // After the last fall, MOSI keeps the final bit through HOLD.
            r_tx_shift <= w_tx_rot;
            r_mosi     <= w_mosi_next;
         end
         if (w_rise) begin
            r_rx_shift <= w_rx_next;
         end
         if (w_lag_end) begin
            r_rx_data <= r_rx_shift;
            r_mosi    <= 1'b0;
         end
      end
   end

   assign o_sclk    = r_sclk;
   assign o_mosi    = r_mosi;
   assign o_cs_n    = r_cs_n;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_rx_data = r_rx_data;

endmodule
